// File: rtl/controle_horda.sv
// controle_horda: fleet controller for the enemy formation.
// Scans the live enemies one per clock, keeps a snapshot of the fleet
// extent and head count, derives the movement clock CLOCK_MV from a
// speed-dependent divisor, reverses the fleet at the screen edges and
// raises the sticky "wave cleared" and "invasion" flags.
module controle_horda #(
  parameter int N_INIMIGOS = 8,
  parameter int LARGURA    = 33,
  parameter int ALTURA     = 24,
  parameter int PASSO      = 2,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 639,
  parameter int Y_LIMITE   = 440,
  parameter int DIV_BASE   = 1000000,
  parameter int DIV_STEP   = 50000,
  parameter int DIV_MIN    = 100000,
  parameter int CW         = $clog2(N_INIMIGOS + 1)
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    pausa,
  input  logic                    reiniciarJogo,
  input  logic [10*N_INIMIGOS-1:0] xs,
  input  logic [10*N_INIMIGOS-1:0] ys,
  input  logic [N_INIMIGOS-1:0]   vivos,
  output logic                    sentidoX,
  output logic                    CLOCK_MV,
  output logic [CW-1:0]           vivos_count,
  output logic                    horda_eliminada,
  output logic                    invasao
);

  localparam int IW = (N_INIMIGOS > 1) ? $clog2(N_INIMIGOS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_INIMIGOS - 1);
  localparam logic [9:0]    X_INIT   = 10'(X_MAX);
  localparam logic [CW-1:0] CNT_FULL = CW'(N_INIMIGOS);

  // Scan state: current index and running accumulators
  logic [IW-1:0] idx_q, idx_d;
  logic [9:0]    acc_min_x_q, acc_min_x_d;
  logic [9:0]    acc_max_x_q, acc_max_x_d;
  logic [9:0]    acc_max_y_q, acc_max_y_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;

  // Snapshot of the last completed scan
  logic [9:0]    snap_min_x_q, snap_min_x_d;
  logic [9:0]    snap_max_x_q, snap_max_x_d;
  logic [9:0]    snap_max_y_q, snap_max_y_d;
  logic [CW-1:0] snap_cnt_q, snap_cnt_d;

  // Movement divisor, direction and flags
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hp_q, hp_d;
  logic        mv_q, mv_d;
  logic        sent_q, sent_d;
  logic        horda_q, horda_d;
  logic        inv_q, inv_d;

  // Combinational helpers
  logic [9:0]    cur_x_s, cur_y_s;
  logic          cur_vivo_s;
  logic [9:0]    run_min_x_s, run_max_x_s, run_max_y_s;
  logic [CW-1:0] run_cnt_s;
  logic [31:0]   dead_s, red_s, hp_new_s;
  logic          borda_dir_s, borda_esq_s;

  // Select the enemy addressed by the scan index
  always_comb begin
    cur_x_s    = 10'd0;
    cur_y_s    = 10'd0;
    cur_vivo_s = 1'b0;
    for (int i = 0; i < N_INIMIGOS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_x_s    = xs[10*i +: 10];
        cur_y_s    = ys[10*i +: 10];
        cur_vivo_s = vivos[i];
      end else begin
        cur_x_s    = cur_x_s;
        cur_y_s    = cur_y_s;
        cur_vivo_s = cur_vivo_s;
      end
    end
  end

  // Fold the selected enemy into the running extent; dead enemies are skipped
  always_comb begin
    run_min_x_s = acc_min_x_q;
    run_max_x_s = acc_max_x_q;
    run_max_y_s = acc_max_y_q;
    run_cnt_s   = acc_cnt_q;
    if (cur_vivo_s) begin
      if (cur_x_s < acc_min_x_q) run_min_x_s = cur_x_s;
      else                       run_min_x_s = acc_min_x_q;
      if (cur_x_s > acc_max_x_q) run_max_x_s = cur_x_s;
      else                       run_max_x_s = acc_max_x_q;
      if (cur_y_s > acc_max_y_q) run_max_y_s = cur_y_s;
      else                       run_max_y_s = acc_max_y_q;
      run_cnt_s = acc_cnt_q + CW'(1);
    end else begin
      run_cnt_s = acc_cnt_q;
    end
  end

  // Advance the scan; on the last enemy commit the snapshot and re-init
  always_comb begin
    idx_d        = idx_q;
    acc_min_x_d  = acc_min_x_q;
    acc_max_x_d  = acc_max_x_q;
    acc_max_y_d  = acc_max_y_q;
    acc_cnt_d    = acc_cnt_q;
    snap_min_x_d = snap_min_x_q;
    snap_max_x_d = snap_max_x_q;
    snap_max_y_d = snap_max_y_q;
    snap_cnt_d   = snap_cnt_q;
    if (reiniciarJogo) begin
      idx_d        = '0;
      acc_min_x_d  = X_INIT;
      acc_max_x_d  = 10'd0;
      acc_max_y_d  = 10'd0;
      acc_cnt_d    = '0;
      snap_min_x_d = X_INIT;
      snap_max_x_d = 10'd0;
      snap_max_y_d = 10'd0;
      snap_cnt_d   = CNT_FULL;
    end else if (idx_q >= IDX_LAST) begin
      idx_d        = '0;
      snap_min_x_d = run_min_x_s;
      snap_max_x_d = run_max_x_s;
      snap_max_y_d = run_max_y_s;
      snap_cnt_d   = run_cnt_s;
      acc_min_x_d  = X_INIT;
      acc_max_x_d  = 10'd0;
      acc_max_y_d  = 10'd0;
      acc_cnt_d    = '0;
    end else begin
      idx_d       = idx_q + IW'(1);
      acc_min_x_d = run_min_x_s;
      acc_max_x_d = run_max_x_s;
      acc_max_y_d = run_max_y_s;
      acc_cnt_d   = run_cnt_s;
    end
  end

  // Half-period from the number of dead enemies, clamped at DIV_MIN
  always_comb begin
    dead_s = 32'(N_INIMIGOS) - 32'(snap_cnt_q);
    red_s  = 32'(DIV_STEP) * dead_s;
    if (red_s >= 32'(DIV_BASE)) begin
      hp_new_s = 32'(DIV_MIN);
    end else if ((32'(DIV_BASE) - red_s) < 32'(DIV_MIN)) begin
      hp_new_s = 32'(DIV_MIN);
    end else begin
      hp_new_s = 32'(DIV_BASE) - red_s;
    end
  end

  // Edge tests against the committed fleet extent
  always_comb begin
    borda_dir_s = (32'(snap_max_x_q) + 32'(LARGURA) + 32'(PASSO)) > 32'(X_MAX);
    borda_esq_s = 32'(snap_min_x_q) < (32'(X_MIN) + 32'(PASSO));
  end

  // Divisor, CLOCK_MV toggle and direction reversal on each rising toggle
  always_comb begin
    cnt_d  = cnt_q;
    hp_d   = hp_q;
    mv_d   = mv_q;
    sent_d = sent_q;
    if (reiniciarJogo) begin
      cnt_d  = 32'd0;
      hp_d   = 32'(DIV_BASE);
      mv_d   = 1'b0;
      sent_d = 1'b1;
    end else if (horda_q) begin
      mv_d = 1'b0;
    end else if (pausa) begin
      cnt_d = cnt_q;
    end else if ((cnt_q + 32'd1) >= hp_q) begin
      cnt_d = 32'd0;
      mv_d  = ~mv_q;
      // the period that starts now uses the freshest speed
      hp_d  = hp_new_s;
      if (!mv_q && (snap_cnt_q != '0)) begin
        if (sent_q && borda_dir_s)       sent_d = 1'b0;
        else if (!sent_q && borda_esq_s) sent_d = 1'b1;
        else                             sent_d = sent_q;
      end else begin
        sent_d = sent_q;
      end
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Sticky wave-cleared and invasion flags, driven from the snapshot
  always_comb begin
    horda_d = horda_q;
    inv_d   = inv_q;
    if (reiniciarJogo) begin
      horda_d = 1'b0;
      inv_d   = 1'b0;
    end else begin
      if (snap_cnt_q == '0) horda_d = 1'b1;
      else                  horda_d = horda_q;
      if ((snap_cnt_q != '0) &&
          ((32'(snap_max_y_q) + 32'(ALTURA)) >= 32'(Y_LIMITE))) inv_d = 1'b1;
      else                                                    inv_d = inv_q;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      idx_q        <= '0;
      acc_min_x_q  <= X_INIT;
      acc_max_x_q  <= 10'd0;
      acc_max_y_q  <= 10'd0;
      acc_cnt_q    <= '0;
      snap_min_x_q <= X_INIT;
      snap_max_x_q <= 10'd0;
      snap_max_y_q <= 10'd0;
      snap_cnt_q   <= CNT_FULL;
      cnt_q        <= 32'd0;
      hp_q         <= 32'(DIV_BASE);
      mv_q         <= 1'b0;
      sent_q       <= 1'b1;
      horda_q      <= 1'b0;
      inv_q        <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      acc_min_x_q  <= acc_min_x_d;
      acc_max_x_q  <= acc_max_x_d;
      acc_max_y_q  <= acc_max_y_d;
      acc_cnt_q    <= acc_cnt_d;
      snap_min_x_q <= snap_min_x_d;
      snap_max_x_q <= snap_max_x_d;
      snap_max_y_q <= snap_max_y_d;
      snap_cnt_q   <= snap_cnt_d;
      cnt_q        <= cnt_d;
      hp_q         <= hp_d;
      mv_q         <= mv_d;
      sent_q       <= sent_d;
      horda_q      <= horda_d;
      inv_q        <= inv_d;
    end
  end

  assign sentidoX        = sent_q;
  assign CLOCK_MV        = mv_q;
  assign vivos_count     = snap_cnt_q;
  assign horda_eliminada = horda_q;
  assign invasao         = inv_q;

endmodule

// File: tb/tb_controle_horda.sv
// Directed bench for controle_horda with a small divisor so the whole
// flow fits in a short run; expected values go into a scoreboard queue
// and are compared when the DUT output is sampled.
module tb_controle_horda;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              pausa;
  logic              reiniciarJogo;
  logic [10*N-1:0]   xs;
  logic [10*N-1:0]   ys;
  logic [N-1:0]      vivos;
  logic              sentidoX;
  logic              CLOCK_MV;
  logic [CW-1:0]     vivos_count;
  logic              horda_eliminada;
  logic              invasao;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  controle_horda #(
    .N_INIMIGOS(N), .LARGURA(33), .ALTURA(24), .PASSO(2),
    .X_MIN(0), .X_MAX(639), .Y_LIMITE(440),
    .DIV_BASE(8), .DIV_STEP(2), .DIV_MIN(2)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .pausa(pausa),
    .reiniciarJogo(reiniciarJogo),
    .xs(xs),
    .ys(ys),
    .vivos(vivos),
    .sentidoX(sentidoX),
    .CLOCK_MV(CLOCK_MV),
    .vivos_count(vivos_count),
    .horda_eliminada(horda_eliminada),
    .invasao(invasao)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0d expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  // cycles until CLOCK_MV changes, -1 on timeout
  task automatic wait_toggle(input int max, output int n);
    logic prev;
    prev = CLOCK_MV;
    n = -1;
    for (int k = 1; k <= max; k++) begin
      tick(1);
      if (CLOCK_MV !== prev) begin
        n = k;
        break;
      end
    end
  endtask

  // wait for the next 0->1 of CLOCK_MV; a timeout counts as a failure
  task automatic wait_rise(input int max);
    logic prev;
    bit   seen;
    seen = 1'b0;
    prev = CLOCK_MV;
    for (int k = 1; k <= max; k++) begin
      tick(1);
      if (prev === 1'b0 && CLOCK_MV === 1'b1) begin
        seen = 1'b1;
        break;
      end
      prev = CLOCK_MV;
    end
    if (!seen) begin
      checks++;
      failures++;
      $error("FAIL rise_timeout observed=none expected=rise within %0d", max);
    end
  endtask

  task automatic set_x(input int i, input int v);
    xs[10*i +: 10] = 10'(v);
  endtask

  task automatic set_y(input int i, input int v);
    ys[10*i +: 10] = 10'(v);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    pausa = 1'b0;
    reiniciarJogo = 1'b0;
    vivos = 8'hFF;
    for (int i = 0; i < N; i++) begin
      set_x(i, 100);
      set_y(i, 50);
    end
    tick(3);

    // reset state
    expect_val("rst_sentidoX", 1); check(32'(sentidoX));
    expect_val("rst_clock_mv", 0); check(32'(CLOCK_MV));
    expect_val("rst_vivos_count", 8); check(32'(vivos_count));
    expect_val("rst_horda", 0); check(32'(horda_eliminada));
    expect_val("rst_invasao", 0); check(32'(invasao));

    // first toggle DIV_BASE cycles after release, then a full half-period
    reset = 1'b0;
    expect_val("first_rise_cycles", 8);
    wait_toggle(50, n); check(32'(n));
    expect_val("first_fall_cycles", 8);
    wait_toggle(50, n); check(32'(n));

    // pause mid-period: CLOCK_MV frozen, phase resumes exactly
    tick(3);
    pausa = 1'b1;
    tick(10);
    expect_val("pause_hold_mv", 0); check(32'(CLOCK_MV));
    pausa = 1'b0;
    expect_val("pause_resume_cycles", 5);
    wait_toggle(50, n); check(32'(n));

    // right edge, exactly at the limit: no flip
    set_x(0, 604);
    wait_rise(100);
    expect_val("edge_604_no_flip", 1); check(32'(sentidoX));

    // one pixel past the limit: flips only at the next rise
    set_x(0, 605);
    tick(12);
    expect_val("edge_605_not_early", 1); check(32'(sentidoX));
    wait_rise(100);
    expect_val("edge_605_flip", 0); check(32'(sentidoX));

    // left edge: min x = 1 < 2 flips back to the right
    set_x(1, 1);
    tick(12);
    expect_val("left_not_early", 0); check(32'(sentidoX));
    wait_rise(100);
    expect_val("left_flip", 1); check(32'(sentidoX));

    // dead enemy past the right edge is ignored
    set_x(1, 100);
    vivos = 8'hFE;
    wait_rise(100);
    wait_rise(100);
    expect_val("dead_edge_no_flip", 1); check(32'(sentidoX));
    expect_val("count_7", 7); check(32'(vivos_count));

    // speed-up: 2 dead -> half-period 4
    vivos = 8'hFC;
    tick(2*N + 2);
    expect_val("count_6", 6); check(32'(vivos_count));
    wait_toggle(50, n);
    expect_val("hp_2dead", 4);
    wait_toggle(50, n); check(32'(n));

    // 3 dead -> half-period 2
    vivos = 8'hF8;
    tick(2*N + 2);
    expect_val("count_5", 5); check(32'(vivos_count));
    wait_toggle(50, n);
    expect_val("hp_3dead", 2);
    wait_toggle(50, n); check(32'(n));

    // 5 dead -> underflow clamps to DIV_MIN
    vivos = 8'hE0;
    tick(2*N + 2);
    expect_val("count_3", 3); check(32'(vivos_count));
    wait_toggle(50, n);
    expect_val("hp_5dead_clamp", 2);
    wait_toggle(50, n); check(32'(n));

    // invasion boundary; a dead enemy deep below is ignored
    set_y(0, 500);
    set_y(5, 415);
    tick(2*N + 2);
    expect_val("invasao_415", 0); check(32'(invasao));
    set_y(5, 416);
    tick(2*N + 2);
    expect_val("invasao_416", 1); check(32'(invasao));
    expect_val("horda_while_alive", 0); check(32'(horda_eliminada));

    // wave cleared: flag set, CLOCK_MV held low
    vivos = 8'h00;
    tick(2*N + 2);
    expect_val("horda_set", 1); check(32'(horda_eliminada));
    expect_val("count_0", 0); check(32'(vivos_count));
    expect_val("horda_mv_low", 0); check(32'(CLOCK_MV));
    tick(40);
    expect_val("horda_mv_held", 0); check(32'(CLOCK_MV));
    expect_val("invasao_sticky", 1); check(32'(invasao));

    // restart clears everything and the divisor starts from zero
    vivos = 8'hFF;
    for (int i = 0; i < N; i++) set_y(i, 50);
    reiniciarJogo = 1'b1;
    tick(1);
    reiniciarJogo = 1'b0;
    expect_val("restart_horda", 0); check(32'(horda_eliminada));
    expect_val("restart_invasao", 0); check(32'(invasao));
    expect_val("restart_count", 8); check(32'(vivos_count));
    expect_val("restart_sentidoX", 1); check(32'(sentidoX));
    expect_val("restart_mv", 0); check(32'(CLOCK_MV));
    expect_val("restart_first_rise", 8);
    wait_toggle(50, n); check(32'(n));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controle_horda.md
Name: controle_horda

Overview:
Fleet controller for the enemy formation. It scans the live enemies' positions and drives the shared movement clock CLOCK_MV and the shared direction bit sentidoX that every enemy instance consumes. It reverses the fleet at the screen edges, which makes each enemy step down on its next CLOCK_MV falling edge. It also speeds the fleet up as enemies die, and flags a cleared wave and an invasion. It sits in the top-level game logic between the enemy array and the game-state FSM.

Parameters:
N_INIMIGOS, 8, number of enemy instances scanned
LARGURA, 33, enemy sprite width in pixels
ALTURA, 24, enemy sprite height in pixels
PASSO, 2, horizontal step per CLOCK_MV period
X_MIN, 0, leftmost legal x
X_MAX, 639, rightmost legal pixel
Y_LIMITE, 440, y at which the fleet has invaded
DIV_BASE, 1000000, CLOCK_MV half-period in CLOCK_50 cycles with all enemies alive
DIV_STEP, 50000, half-period reduction per dead enemy
DIV_MIN, 100000, minimum half-period
CW, $clog2(N_INIMIGOS+1), width of the live-enemy counter

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
pausa  in  1  freezes the movement divisor and CLOCK_MV
reiniciarJogo  in  1  synchronous restart; same effect as reset
xs  in  10*N_INIMIGOS  packed enemy x; enemy i at [10i+9:10i]
ys  in  10*N_INIMIGOS  packed enemy y, same packing as xs
vivos  in  N_INIMIGOS  enemy alive mask
sentidoX  out  1  fleet direction, 1 = right, 0 = left
CLOCK_MV  out  1  movement clock; enemies act on its falling edge
vivos_count  out  CW  live enemies in the last completed scan
horda_eliminada  out  1  sticky: all enemies dead
invasao  out  1  sticky: a live enemy reached Y_LIMITE

Behaviour:
- Reset, or reiniciarJogo at a clock edge, sets:
  - sentidoX=1, CLOCK_MV=0, divisor count=0, scan idx=0;
  - snapshot min_x=X_MAX, max_x=0, max_y=0, count=N_INIMIGOS;
  - vivos_count=N_INIMIGOS, horda_eliminada=0, invasao=0.
- Scan runs every CLOCK_50 cycle, including while paused:
  - idx steps 0..N-1 and wraps.
  - If vivos[idx]=1, enemy idx updates the running min x, max x, max y and count; dead enemies are ignored.
  - On the cycle idx=N-1 is processed, the running values including enemy N-1 go to the snapshot registers and the accumulators re-init.
  - Snapshot latency is N cycles; it is visible on vivos_count the cycle after commit.
- Half-period = max(DIV_MIN, DIV_BASE - DIV_STEP*(N - snapshot count)).
  - Computed with unsigned width ≥32 bits; underflow clamps to DIV_MIN.
- Divisor, when pausa=0 and horda_eliminada=0:
  - The counter increments each cycle.
  - When counter ≥ half-period-1, the counter returns to 0 and CLOCK_MV toggles.
  - A new half-period takes effect at the next toggle.
- pausa=1: counter and CLOCK_MV hold their values.
- Direction decision is made only on a CLOCK_MV 0→1 toggle, and only when snapshot count > 0:
  - If sentidoX=1 and max_x + LARGURA + PASSO > X_MAX, sentidoX becomes 0.
  - If sentidoX=0 and min_x < X_MIN + PASSO, sentidoX becomes 1.
  - At most one flip per CLOCK_MV period.
  - Enemies sample the new sentidoX half a period later, on the falling edge, and descend.
- horda_eliminada: set the cycle after a snapshot commits with count=0; then CLOCK_MV is forced to 0 and the counter is held.
- invasao: set the cycle after a snapshot with count>0 and max_y + ALTURA ≥ Y_LIMITE.
- Both flags are sticky until reset or reiniciarJogo. Both may set in the same cycle only if the same snapshot qualifies, which cannot happen (count>0 vs count=0).
- Reset mid-scan discards partial accumulators; the divisor restarts from 0.

Test Plan:
1. Reset → sentidoX=1, CLOCK_MV=0, vivos_count=8, both flags 0; release → first CLOCK_MV toggle after DIV_BASE cycles.
2. DIV_BASE=4, all alive, pausa=0 → CLOCK_MV period 8 cycles; pausa=1 for 10 cycles mid-period → CLOCK_MV and phase frozen, resume exact.
3. Right edge: enemy0 x=604, others x=100, sentidoX=1 → 604+33+2=639, no flip; x=605 → 640>639, sentidoX=0 at next CLOCK_MV rise, not before.
4. Same as case 3 but vivos[0]=0 → no flip. Left edge: sentidoX=0, min x=1 → flips to 1 at next rise.
5. Speed-up with DIV_BASE=8, DIV_STEP=2, DIV_MIN=2:
   - 2 dead → half-period 4;
   - 3 dead → 2;
   - 5 dead → clamped 2;
   - vivos_count tracks within N+1 cycles.
6. Flags:
   - vivos=0 → horda_eliminada=1 within N+1 cycles and CLOCK_MV held 0;
   - live enemy y=416 (416+24=440) → invasao=1;
   - reiniciarJogo → both flags clear.
